// File: rtl/aoi222_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// aoi222_rr_arbiter_if
//   Bundles the request/data/grant signals of the three-leg AOI222 arbiter.
//   The master side belongs to the requesters. The slave side belongs to the
//   arbiter.
//
//   REQ   [2:0]        requests: bit 0 = A, bit 1 = B, bit 2 = C (level)
//   DIN_A/B/C [WIDTH]  data legs
//   GNT   [2:0]        registered one-hot grant, 0 when idle
//   BUSY               registered, 1 while a grant is held
//   ZN    [WIDTH]      ~(granted leg); all ones when idle
// ---------------------------------------------------------------------------
interface aoi222_rr_arbiter_if #(
  parameter int WIDTH = 1
);
  logic [2:0]       REQ;
  logic [WIDTH-1:0] DIN_A;
  logic [WIDTH-1:0] DIN_B;
  logic [WIDTH-1:0] DIN_C;
  logic [2:0]       GNT;
  logic             BUSY;
  logic [WIDTH-1:0] ZN;

  modport master (output REQ, DIN_A, DIN_B, DIN_C, input  GNT, BUSY, ZN);
  modport slave  (input  REQ, DIN_A, DIN_B, DIN_C, output GNT, BUSY, ZN);
endinterface

// File: rtl/aoi222_rr_arbiter.sv
// ---------------------------------------------------------------------------
// aoi222_rr_arbiter
//   This is a round-robin arbiter for a shared inverting select path. It
//   grants one of three requesters, A, B or C. It then drives
//   ZN = ~((GNT[0]&DIN_A) | (GNT[1]&DIN_B) | (GNT[2]&DIN_C)).
//   A hold limit (MAX_HOLD) caps how long an owner keeps the path while
//   another requester waits.
//
//   Ports:
//     CLK  clock, rising edge
//     RST  synchronous, active-high reset
//     bus  aoi222_rr_arbiter_if.slave (REQ, DIN_A/B/C in; GNT, BUSY, ZN out)
//
//   Parameters:
//     WIDTH     width of each data leg and of ZN
//     MAX_HOLD  maximum consecutive owned cycles while others wait (1..255)
//
//   Build option:
//     AOI222_ARB_REG_OUT_EN  When this is defined, ZN is registered and lags
//                            by one cycle. When it is undefined, ZN is
//                            combinational.
// ---------------------------------------------------------------------------
module aoi222_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                CLK,
  input  logic                RST,
  aoi222_rr_arbiter_if.slave  bus
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e        state_q, state_d;
  logic [2:0]    gnt_q,   gnt_d;
  logic [1:0]    last_q,  last_d;   // index of the most recent winner
  logic [CW-1:0] cnt_q,   cnt_d;

  logic [2:0]    others;
  logic [1:0]    win_idx;
  logic [WIDTH-1:0] zn_comb;

  // The search starts just after 'last' and wraps A->B->C->A. The loop runs
  // from the farthest candidate down to the nearest, so the nearest pending
  // requester is written last and wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    int         j;
    idx = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      j = (int'(last) + k) % 3;
      if (req[j]) idx = 2'(j);
    end
    return idx;
  endfunction

  // When idle, gnt_q is zero, so 'others' equals the full request vector.
  // One search therefore covers both the initial grant and any handoff.
  assign others  = bus.REQ & ~gnt_q;
  assign win_idx = rr_pick(others, last_q);

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.REQ) begin
          state_d = OWN;
          gnt_d   = 3'b001 << win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (~|(bus.REQ & gnt_q)) begin
          // The owner has released. Hand off directly, or go idle.
          cnt_d = '0;
          if (|others) begin
            gnt_d  = 3'b001 << win_idx;
            last_d = win_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
          end
        end else if (|others) begin
          if (cnt_q == HOLD_LAST) begin
            // Timeout: move to the next waiter with no idle bubble.
            gnt_d  = 3'b001 << win_idx;
            last_d = win_idx;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != HOLD_LAST) begin
          // The owner is alone. The counter saturates and no timeout fires.
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      last_q  <= 2'd2;   // A has first priority after reset
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign zn_comb = ~(({WIDTH{gnt_q[0]}} & bus.DIN_A) |
                     ({WIDTH{gnt_q[1]}} & bus.DIN_B) |
                     ({WIDTH{gnt_q[2]}} & bus.DIN_C));

  assign bus.GNT  = gnt_q;
  assign bus.BUSY = (state_q == OWN);

`ifdef AOI222_ARB_REG_OUT_EN
  logic [WIDTH-1:0] zn_q;
  always_ff @(posedge CLK) begin
    if (RST) zn_q <= '1;
    else     zn_q <= zn_comb;
  end
  assign bus.ZN = zn_q;
`else
  assign bus.ZN = zn_comb;
`endif

endmodule

// File: tb/tb_aoi222_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aoi222_rr_arbiter
//   Directed bench for aoi222_rr_arbiter with WIDTH = 4 and MAX_HOLD = 4.
//   The expected grants below are worked out by hand. The expected ZN comes
//   from the output equation, applied to the expected grant. In the
//   registered-output build, it is taken one cycle late.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aoi222_rr_arbiter;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  aoi222_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  aoi222_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_gnt = 3'b000;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_zn(input logic [2:0] g);
    return ~(({WIDTH{g[0]}} & bus.DIN_A) | ({WIDTH{g[1]}} & bus.DIN_B) |
             ({WIDTH{g[2]}} & bus.DIN_C));
  endfunction

  // This task advances one edge. It then checks GNT, BUSY and ZN against
  // the hand-computed grant for that edge.
  task automatic cycle(input string tag, input logic [2:0] g);
    logic [WIDTH-1:0] prev_zn;
    logic             rst_at_edge;
    logic [WIDTH-1:0] zexp;
    prev_zn     = model_zn(exp_gnt);
    rst_at_edge = RST;
    @(posedge CLK);
    #2;
    exp_gnt = g;
`ifdef AOI222_ARB_REG_OUT_EN
    zexp = rst_at_edge ? '1 : prev_zn;
`else
    zexp = model_zn(exp_gnt);
`endif
    check({tag, ".gnt"},  32'(bus.GNT),  32'(g));
    check({tag, ".busy"}, 32'(bus.BUSY), 32'(|g));
    check({tag, ".zn"},   32'(bus.ZN),   32'(zexp));
  endtask

  initial begin
    bus.REQ   = 3'b111;
    bus.DIN_A = 4'h3;
    bus.DIN_B = 4'hA;
    bus.DIN_C = 4'hC;

    // 1. Reset holds everything idle, even with all requests high.
    RST = 1'b1;
    cycle("rst0", 3'b000);
    cycle("rst1", 3'b000);
    check("rst.zn_ones", 32'(bus.ZN), 32'(4'hF));
    RST = 1'b0;
    cycle("rst_rel", 3'b001);          // pointer = C, so A wins
    bus.REQ = 3'b000;
    cycle("a_rel", 3'b000);

    // 2. B alone holds the grant well past MAX_HOLD.
    bus.REQ = 3'b010;
    cycle("b_first", 3'b010);
`ifdef AOI222_ARB_REG_OUT_EN
    check("b_first.zn_lag", 32'(bus.ZN), 32'(4'hF));
`else
    check("b_first.zn_5", 32'(bus.ZN), 32'(4'h5));
`endif
    for (int i = 0; i < 9; i++) cycle("b_hold", 3'b010);
    check("b_hold.zn_5", 32'(bus.ZN), 32'(4'h5));
    bus.REQ = 3'b000;
    cycle("b_rel", 3'b000);

    // 3. Timeout: A gets 4 cycles, then B takes over with no bubble.
    bus.REQ = 3'b011;
    cycle("to_a0", 3'b001);
    cycle("to_a1", 3'b001);
    bus.DIN_A = 4'h6;                  // the live data path must follow DIN
    cycle("to_a2", 3'b001);
    cycle("to_a3", 3'b001);
    cycle("to_b0", 3'b010);
    cycle("to_b1", 3'b010);
    cycle("to_b2", 3'b010);
    cycle("to_b3", 3'b010);
    cycle("to_a_back", 3'b001);
    bus.REQ = 3'b000;
    cycle("to_idle", 3'b000);

    // 4. A release hands off directly. It wraps after C, then goes idle.
    bus.REQ = 3'b100;
    cycle("c_own", 3'b100);
    bus.REQ = 3'b011;                  // C drops; A and B pending
    cycle("c_to_a", 3'b001);
    bus.REQ = 3'b110;                  // A drops (and C re-requests)
    cycle("a_to_b", 3'b010);
    bus.REQ = 3'b000;
    cycle("rel_idle", 3'b000);

    // 5. A reset during C's grant restores the pointer to C, so A wins next.
    bus.REQ = 3'b100;
    cycle("c_own2", 3'b100);
    bus.REQ = 3'b111;
    RST = 1'b1;
    cycle("mid_rst", 3'b000);
    RST = 1'b0;
    cycle("post_rst", 3'b001);
    bus.REQ = 3'b000;
    cycle("end_idle", 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aoi222_rr_arbiter.md
Name: aoi222_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a shared three-leg AND-OR-INVERT select path (aoi222 function). Three requesters each present a data word. The block issues a registered one-hot grant and drives ZN = ~((GNT[0]&DIN_A) | (GNT[1]&DIN_B) | (GNT[2]&DIN_C)) bitwise. A hold limit bounds how long one requester may own the path. It sits in front of the shared inverting select path in MCU glue logic.

Parameters:
WIDTH, 1, bit width of each data leg and of ZN
MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant while others wait (legal range 1..255)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-high
REQ  input  3  request: bit 0 = A, bit 1 = B, bit 2 = C; level-sensitive
DIN_A  input  WIDTH  data leg A
DIN_B  input  WIDTH  data leg B
DIN_C  input  WIDTH  data leg C
GNT  output  3  registered one-hot grant, or 0 when idle
BUSY  output  1  registered; 1 when GNT != 0
ZN  output  WIDTH  inverted AND-OR of granted leg; all ones when GNT = 0

Behaviour:
- One clock; reset is synchronous and active-high (CLK, RST). RST sampled high at a rising edge forces the following:
  - GNT = 3'b000, BUSY = 0.
  - Hold counter = 0.
  - Round-robin pointer LAST = 2, so A has first priority.
  - ZN = all ones.
  - RST overrides any grant in progress. There is no partial handoff.
- States:
  - IDLE: GNT = 0.
  - OWN: exactly one GNT bit is set.
- Priority order: search starts at (LAST+1) mod 3 and wraps: A→B→C→A.
- IDLE→OWN:
  - Any REQ bit sampled high → GNT = winner at the next edge. Latency is 1 cycle.
  - LAST = winner. Counter = 0.
- OWN, owner REQ still high, no other REQ: stay. The counter saturates at MAX_HOLD-1, and no timeout fires.
- OWN, owner REQ high, other REQ pending, counter < MAX_HOLD-1: stay, counter += 1.
- OWN, owner REQ high, other REQ pending, counter == MAX_HOLD-1 (timeout):
  - Grant moves to the next pending requester in round-robin order after the owner, at the next edge.
  - Counter = 0. No idle bubble.
- OWN, owner REQ low (release):
  - If another REQ is high, grant hands off directly to the next one in round-robin order at the next edge. Counter = 0.
  - Otherwise GNT = 0 and go to IDLE.
- MAX_HOLD = 1: the owner loses the grant after every cycle whenever another requester is pending.
- Simultaneous requests: resolved purely by the pointer. The same-cycle release and new request of one requester counts as a release.
- GNT is one-hot or zero in every cycle. BUSY = |GNT.
- Without the optional feature, ZN is combinational from registered GNT and the live DIN_*. The DIN to ZN path is purely combinational.
- The counter width is the smallest width that holds MAX_HOLD-1 (minimum 1).

Optional Feature:
- Macro: AOI222_ARB_REG_OUT_EN.
- When defined: ZN is registered. It updates at the edge after the GNT/DIN values that produce it, adding 1 cycle of latency. It resets to all ones under RST.
- When undefined: ZN is combinational as described in Behaviour.
- GNT/BUSY timing is identical in both builds.

Test Plan:
1. Reset check. Assert RST for 2 cycles with REQ = 3'b111 → GNT = 0, BUSY = 0, ZN = all ones. First edge after RST deasserts → GNT = 3'b001.
2. Single requester, WIDTH = 4. REQ = 3'b010, DIN_B = 4'hA → next cycle GNT = 3'b010, ZN = 4'h5. Held for 10 cycles, with no timeout since nobody else is requesting.
3. Timeout, MAX_HOLD = 4. REQ = 3'b011 from idle → A granted for 4 cycles, then GNT = 3'b010 with no idle cycle between grants.
4. Release handoff. Owner C drops REQ while A and B are pending → next GNT = 3'b001 (wrap after C). If nothing is pending → GNT = 0 and BUSY = 0 the next cycle.
5. Reset mid-operation. Assert RST while GNT = 3'b100 → GNT = 0 next edge. After release with REQ = 3'b111 → A wins, confirming the pointer is restored.
6. Build with AOI222_ARB_REG_OUT_EN, repeating scenario 2 → ZN = 4'h5 appears one cycle after GNT = 3'b010, and ZN = 4'hF during reset.
